shared_bus_arbiter: RTL and testbench

Round-robin arbiter that time-shares one tri-state / interconnect bus among `N_REQ` drivers. Only one driver's output enable is asserted at a time. Every ownership change inserts a driven-nobody turnaround gap, so no two drivers ever fight on the net. A hold limit preempts a long owner when others are waiting. It sits between the lane drivers and the shared `tri`/`interconnect` bus, next to the bus keeper (`trireg`-style charge node).

---
 rtl/bus_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 27 ++
 rtl/shared_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_shared_bus_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the shared-bus round-robin arbiter.
// Imported by the picker and the arbiter top.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } arb_state_e;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_HOLD_MAX = 16;
    localparam int DEF_TURN_CYC = 1;

    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit above last, wrapping.
// The previous winner is scanned last, so it only wins when nobody else asks.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N = DEF_N_REQ,
    parameter int W = owner_w(DEF_N_REQ)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         valid,
    output logic [W-1:0] idx
);

    // Scan downward so the closest candidate after last is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(last) + i) % N]) begin
                valid = 1'b1;
                idx   = W'((int'(last) + i) % N);
            end
        end
    end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus with a turnaround gap
// between owners and a hold limit that preempts long owners.
module shared_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int HOLD_MAX = DEF_HOLD_MAX,
    parameter int TURN_CYC = DEF_TURN_CYC
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    output logic [N_REQ-1:0]           grant,
    output logic [owner_w(N_REQ)-1:0]  owner,
    output logic                       bus_busy,
    output logic                       preempt
);

    localparam int OW = owner_w(N_REQ);
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

    arb_state_e       state, state_n;
    logic [N_REQ-1:0] grant_n;
    logic [N_REQ-1:0] others;
    logic [OW-1:0]    owner_n, last, last_n;
    logic [HW-1:0]    hold_cnt, hold_n;
    logic [TW-1:0]    turn_cnt, turn_n;
    logic             preempt_n, busy_n;
    logic             pick_valid;
    logic [OW-1:0]    pick_idx;

    rr_pick #(
        .N (N_REQ),
        .W (OW)
    ) u_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            last     <= OW'(N_REQ - 1);
            hold_cnt <= '0;
            turn_cnt <= '0;
            bus_busy <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            owner    <= owner_n;
            last     <= last_n;
            hold_cnt <= hold_n;
            turn_cnt <= turn_n;
            bus_busy <= busy_n;
            preempt  <= preempt_n;
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        owner_n   = owner;
        last_n    = last;
        hold_n    = hold_cnt;
        turn_n    = turn_cnt;
        preempt_n = 1'b0;
        others    = req;
        others[owner] = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n = GRANT;
                    grant_n = '0;
                    grant_n[pick_idx] = 1'b1;
                    owner_n = pick_idx;
                    last_n  = pick_idx;
                    hold_n  = '0;
                end
            end
            GRANT: begin
                // A normal release takes priority over a coinciding expiry.
                if (!req[owner]) begin
                    state_n = TURN;
                    grant_n = '0;
                    turn_n  = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    if (|others) begin
                        state_n   = TURN;
                        grant_n   = '0;
                        turn_n    = '0;
                        preempt_n = 1'b1;
                    end else begin
                        hold_n = '0;
                    end
                end else begin
                    hold_n = hold_cnt + HW'(1);
                end
            end
            TURN: begin
                grant_n = '0;
                if (turn_cnt == TURN_LAST) begin
                    if (pick_valid) begin
                        state_n = GRANT;
                        grant_n[pick_idx] = 1'b1;
                        owner_n = pick_idx;
                        last_n  = pick_idx;
                        hold_n  = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    turn_n = turn_cnt + TW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed and constrained-random checks for shared_bus_arbiter
// (N_REQ=4, HOLD_MAX=4, TURN_CYC=1).
module tb_shared_bus_arbiter;

    localparam int N     = 4;
    localparam int HOLD  = 4;
    localparam int TURN  = 1;
    localparam int BOUND = (N - 1) * (HOLD + TURN) + TURN;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [1:0]   owner;
    logic         bus_busy;
    logic         preempt;

    int n_checks;
    int n_fail;

    shared_bus_arbiter #(
        .N_REQ    (N),
        .HOLD_MAX (HOLD),
        .TURN_CYC (TURN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .grant    (grant),
        .owner    (owner),
        .bus_busy (bus_busy),
        .preempt  (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 4;
        if (grant !== 4'b0000) begin
            n_fail++; $display("FAIL reset_grant got %b want 0000", grant);
        end
        if (owner !== 2'd0) begin
            n_fail++; $display("FAIL reset_owner got %0d want 0", owner);
        end
        if (bus_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b want 0", bus_busy);
        end
        if (preempt !== 1'b0) begin
            n_fail++; $display("FAIL reset_preempt got %b want 0", preempt);
        end
        rst_n = 1'b1;
        step();
        n_checks += 3;
        if (grant !== 4'b0001) begin
            n_fail++; $display("FAIL first_grant got %b want 0001", grant);
        end
        if (owner !== 2'd0) begin
            n_fail++; $display("FAIL first_owner got %0d want 0", owner);
        end
        if (bus_busy !== 1'b1) begin
            n_fail++; $display("FAIL first_busy got %b want 1", bus_busy);
        end
    endtask

    task automatic test_release();
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks += 2;
            if (grant !== 4'b0001) begin
                n_fail++; $display("FAIL rel_hold[%0d] got %b want 0001", i, grant);
            end
            if (bus_busy !== 1'b1) begin
                n_fail++; $display("FAIL rel_busy[%0d] got %b want 1", i, bus_busy);
            end
        end
        req = 4'b0100;
        step();
        n_checks += 2;
        if (grant !== 4'b0000) begin
            n_fail++; $display("FAIL rel_gap got %b want 0000", grant);
        end
        if (bus_busy !== 1'b1) begin
            n_fail++; $display("FAIL rel_gap_busy got %b want 1", bus_busy);
        end
        step();
        n_checks += 3;
        if (grant !== 4'b0100) begin
            n_fail++; $display("FAIL rel_next got %b want 0100", grant);
        end
        if (owner !== 2'd2) begin
            n_fail++; $display("FAIL rel_owner got %0d want 2", owner);
        end
        if (bus_busy !== 1'b1) begin
            n_fail++; $display("FAIL rel_next_busy got %b want 1", bus_busy);
        end
    endtask

    task automatic test_preempt();
        logic [3:0] exp [14];
        exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                4'b0001, 4'b0001, 4'b0001, 4'b0001};
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 14; i++) begin
            step();
            n_checks += 2;
            if (grant !== exp[i]) begin
                n_fail++; $display("FAIL pre_grant[%0d] got %b want %b", i, grant, exp[i]);
            end
            if (preempt !== (exp[i] == 4'b0000)) begin
                n_fail++; $display("FAIL pre_pulse[%0d] got %b want %b", i, preempt, exp[i] == 4'b0000);
            end
        end
    endtask

    task automatic test_no_preempt();
        do_reset();
        req = 4'b1000;
        for (int i = 0; i < 40; i++) begin
            step();
            n_checks += 2;
            if (grant !== 4'b1000) begin
                n_fail++; $display("FAIL solo_grant[%0d] got %b want 1000", i, grant);
            end
            if (preempt !== 1'b0) begin
                n_fail++; $display("FAIL solo_preempt[%0d] got %b want 0", i, preempt);
            end
        end
    endtask

    task automatic test_coincide();
        do_reset();
        req = 4'b0011;
        repeat (4) step();
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++; $display("FAIL coin_pre got %b want 0001", grant);
        end
        req = 4'b0010;
        step();
        n_checks += 2;
        if (grant !== 4'b0000) begin
            n_fail++; $display("FAIL coin_gap got %b want 0000", grant);
        end
        if (preempt !== 1'b0) begin
            n_fail++; $display("FAIL coin_preempt got %b want 0", preempt);
        end
        step();
        n_checks += 2;
        if (grant !== 4'b0010) begin
            n_fail++; $display("FAIL coin_next got %b want 0010", grant);
        end
        if (owner !== 2'd1) begin
            n_fail++; $display("FAIL coin_owner got %0d want 1", owner);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        step();
        n_checks++;
        if (grant !== 4'b0100) begin
            n_fail++; $display("FAIL ar_pre got %b want 0100", grant);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (grant !== 4'b0000) begin
            n_fail++; $display("FAIL ar_grant got %b want 0000", grant);
        end
        if (owner !== 2'd0) begin
            n_fail++; $display("FAIL ar_owner got %0d want 0", owner);
        end
        if (bus_busy !== 1'b0) begin
            n_fail++; $display("FAIL ar_busy got %b want 0", bus_busy);
        end
        req = 4'b0101;
        #1;
        rst_n = 1'b1;
        step();
        n_checks += 2;
        if (grant !== 4'b0001) begin
            n_fail++; $display("FAIL ar_restart got %b want 0001", grant);
        end
        if (owner !== 2'd0) begin
            n_fail++; $display("FAIL ar_restart_owner got %0d want 0", owner);
        end
    endtask

    task automatic test_random();
        int         wait_cnt [N];
        int         zero_run;
        logic [N-1:0] prev;
        bit         have_prev;
        do_reset();
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        zero_run  = 0;
        prev      = '0;
        have_prev = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    if ($urandom_range(5) == 0) req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(3) == 0) req[i] = 1'b1;
                end
            end
            step();
            n_checks++;
            if ((grant & (grant - 1'b1)) !== '0) begin
                n_fail++; $display("FAIL rnd_onehot cyc %0d got %b want <=1 bit", c, grant);
            end
            if (grant == '0) begin
                zero_run++;
            end else begin
                n_checks++;
                if (have_prev && grant != prev && zero_run < TURN) begin
                    n_fail++;
                    $display("FAIL rnd_gap cyc %0d got %0d idle want >=%0d", c, zero_run, TURN);
                end
                prev      = grant;
                have_prev = 1'b1;
                zero_run  = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (req[i] && !grant[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
            end
            n_checks++;
            for (int i = 0; i < N; i++) begin
                if (wait_cnt[i] > BOUND) begin
                    n_fail++;
                    $display("FAIL rnd_wait cyc %0d req %0d got %0d want <=%0d", c, i, wait_cnt[i], BOUND);
                    wait_cnt[i] = 0;
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        req      = '0;
        test_reset();
        test_release();
        test_preempt();
        test_no_preempt();
        test_coincide();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
